// File: rtl/pe_ofmap_writer.sv
// Output feature-map writer: FWFT vector FIFO with raster tagging and feeder throttle.
// Optional frame checksum enabled by defining OFMAP_CHECKSUM_EN.
module pe_ofmap_writer #(
  parameter int OUT_WIDTH    = 513,
  parameter int OUT_HEIGHT   = 257,
  parameter int OUT_CHANNEL  = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int STALL_MARGIN = 12
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_WIDTH*OUT_CHANNEL-1:0]   i_data,
  input  logic                                i_valid,
  output logic [DATA_WIDTH*OUT_CHANNEL-1:0]   o_data,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [$clog2(OUT_WIDTH)-1:0]        o_x,
  output logic [$clog2(OUT_HEIGHT)-1:0]       o_y,
  output logic                                o_last_col,
  output logic                                o_last_frame,
  output logic                                o_stall,
  output logic                                o_overflow
`ifdef OFMAP_CHECKSUM_EN
  ,
  output logic [31:0]                         o_frame_sum,
  output logic                                o_frame_sum_valid
`endif
);

  localparam int VEC_W = DATA_WIDTH * OUT_CHANNEL;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int X_W   = $clog2(OUT_WIDTH);
  localparam int Y_W   = $clog2(OUT_HEIGHT);

  localparam logic [CNT_W-1:0] DEPTH  = CNT_W'(FIFO_DEPTH);
  localparam logic [X_W-1:0]   X_LAST = X_W'(OUT_WIDTH - 1);
  localparam logic [Y_W-1:0]   Y_LAST = Y_W'(OUT_HEIGHT - 1);

  logic [VEC_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] free_slots;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;
  logic             overflow_q;
  logic             full;
  logic             pop;
  logic             push;

  assign full       = (count == DEPTH);
  assign o_valid    = (count != '0);
  assign pop        = o_valid && i_ready;
  assign push       = i_valid && (!full || pop);
  assign free_slots = DEPTH - count;

  // Asynchronous read gives first-word-fall-through; the head entry is
  // not rewritten while it is the head, so o_data holds under backpressure.
  assign o_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Raster position of the head beat; only a completed handshake moves it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (pop) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (i_valid && full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  assign o_x          = x_q;
  assign o_y          = y_q;
  assign o_last_col   = o_valid && (x_q == X_LAST);
  assign o_last_frame = o_last_col && (y_q == Y_LAST);
  assign o_overflow   = overflow_q;

  // The PE keeps delivering vectors for its pipeline depth after a stall,
  // so the throttle fires while that many slots are still free.
  assign o_stall = (32'(free_slots) <= 32'(STALL_MARGIN));

`ifdef OFMAP_CHECKSUM_EN
  logic [31:0] acc;
  logic [31:0] pop_sum;

  always_comb begin
    pop_sum = '0;
    for (int c = 0; c < OUT_CHANNEL; c++) begin
      pop_sum = pop_sum + 32'($signed(o_data[c*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc               <= '0;
      o_frame_sum       <= '0;
      o_frame_sum_valid <= 1'b0;
    end else begin
      o_frame_sum_valid <= 1'b0;
      if (pop) begin
        if (o_last_frame) begin
          o_frame_sum       <= acc + pop_sum;
          o_frame_sum_valid <= 1'b1;
          acc               <= '0;
        end else begin
          acc <= acc + pop_sum;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_pe_ofmap_writer.sv
// Self-checking bench for pe_ofmap_writer: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the writer.
module tb_pe_ofmap_writer;

  localparam int OW     = 3;
  localparam int OH     = 2;
  localparam int OC     = 2;
  localparam int DW     = 16;
  localparam int FD     = 4;
  localparam int SM     = 1;
  localparam int VW     = DW * OC;
  localparam int FRAME  = OW * OH;
  localparam int MSTORE = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [VW-1:0] i_data = '0;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic [VW-1:0] o_data;
  logic          o_valid;
  logic [1:0]    o_x;
  logic [0:0]    o_y;
  logic          o_last_col;
  logic          o_last_frame;
  logic          o_stall;
  logic          o_overflow;
`ifdef OFMAP_CHECKSUM_EN
  logic [31:0]   o_frame_sum;
  logic          o_frame_sum_valid;
`endif

  int vectors = 0;
  int miscompares = 0;

  pe_ofmap_writer #(
    .OUT_WIDTH(OW), .OUT_HEIGHT(OH), .OUT_CHANNEL(OC),
    .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .STALL_MARGIN(SM)
  ) dut (
    .clk(clk), .rst(rst),
    .i_data(i_data), .i_valid(i_valid),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_x(o_x), .o_y(o_y),
    .o_last_col(o_last_col), .o_last_frame(o_last_frame),
    .o_stall(o_stall), .o_overflow(o_overflow)
`ifdef OFMAP_CHECKSUM_EN
    , .o_frame_sum(o_frame_sum), .o_frame_sum_valid(o_frame_sum_valid)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: an unbounded list of accepted vectors with head/tail
  // indices, and a running beat number within the frame.
  logic [VW-1:0] store [MSTORE];
  int            head = 0;
  int            tail = 0;
  int            beat = 0;
  logic          movf = 1'b0;
  logic [31:0]   macc = '0;
  logic [31:0]   msum = '0;
  logic          msum_v = 1'b0;
  int            m_size;
  logic          m_pop;
  logic          m_push;

  assign m_size = tail - head;
  assign m_pop  = (m_size > 0) && i_ready;
  assign m_push = i_valid && ((m_size < FD) || m_pop);

  function automatic logic [31:0] wordSum(input logic [VW-1:0] v);
    int s;
    int w;
    s = 0;
    for (int c = 0; c < OC; c++) begin
      w = $signed(v[c*DW +: DW]);
      s = s + w;
    end
    return 32'(s);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      head   <= 0;
      tail   <= 0;
      beat   <= 0;
      movf   <= 1'b0;
      macc   <= '0;
      msum   <= '0;
      msum_v <= 1'b0;
    end else begin
      msum_v <= 1'b0;
      if (m_pop) begin
        head <= head + 1;
        beat <= (beat + 1) % FRAME;
        if (beat == FRAME - 1) begin
          msum   <= macc + wordSum(store[head % MSTORE]);
          msum_v <= 1'b1;
          macc   <= '0;
        end else begin
          macc <= macc + wordSum(store[head % MSTORE]);
        end
      end
      if (m_push) begin
        store[tail % MSTORE] <= i_data;
        tail <= tail + 1;
      end
      if (i_valid && !m_push) begin
        movf <= 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("valid", 64'(o_valid), 64'(m_size != 0));
    if (m_size != 0) begin
      checkOutput("data", 64'(o_data), 64'(store[head % MSTORE]));
    end
    checkOutput("x", 64'(o_x), 64'(beat % OW));
    checkOutput("y", 64'(o_y), 64'(beat / OW));
    checkOutput("last_col", 64'(o_last_col), 64'((m_size != 0) && (beat % OW == OW - 1)));
    checkOutput("last_frame", 64'(o_last_frame), 64'((m_size != 0) && (beat == FRAME - 1)));
    checkOutput("stall", 64'(o_stall), 64'((FD - m_size) <= SM));
    checkOutput("overflow", 64'(o_overflow), 64'(movf));
`ifdef OFMAP_CHECKSUM_EN
    checkOutput("sum_valid", 64'(o_frame_sum_valid), 64'(msum_v));
    checkOutput("sum", 64'(o_frame_sum), 64'(msum));
`endif
  end

  task automatic applyStimulus(input logic v, input logic [VW-1:0] d, input logic r);
    @(negedge clk);
    i_valid = v;
    i_data  = d;
    i_ready = r;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst     = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  logic [1:0] pin_x  [1:7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
  logic       pin_y  [1:7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       pin_lc [1:7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       pin_lf [1:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic pinBeat(input int b);
    checkOutput("pin1_valid", 64'(o_valid), 64'd1);
    checkOutput("pin1_data", 64'(o_data), 64'({16'(b), 16'(b - 1)}));
    checkOutput("pin1_x", 64'(o_x), 64'(pin_x[b]));
    checkOutput("pin1_y", 64'(o_y), 64'(pin_y[b]));
    checkOutput("pin1_last_col", 64'(o_last_col), 64'(pin_lc[b]));
    checkOutput("pin1_last_frame", 64'(o_last_frame), 64'(pin_lf[b]));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef OFMAP_CHECKSUM_EN
    int pulses;
    logic [31:0] seen_sum;
`endif
    int rp;
    #1 rst = 1'b1;
    #2;
    checkOutput("rst_valid", 64'(o_valid), 64'd0);
    checkOutput("rst_x", 64'(o_x), 64'd0);
    checkOutput("rst_stall", 64'(o_stall), 64'd0);
    checkOutput("rst_overflow", 64'(o_overflow), 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Back-to-back stream through a full frame and into the next.
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b1, {16'(k), 16'(k - 1)}, 1'b1);
      #1;
      if (k >= 2) pinBeat(k - 1);
    end
    applyStimulus(1'b0, '0, 1'b1);
    #1 pinBeat(7);

    // Fill under backpressure, overflow, then drain.
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 32'hA000_0000 + 32'(k), 1'b0);
      #1;
      if (k == 3) checkOutput("pin2_stall_c2", 64'(o_stall), 64'd0);
      if (k == 4) checkOutput("pin2_stall_c3", 64'(o_stall), 64'd1);
      if (k == 5) checkOutput("pin2_ovf_c4", 64'(o_overflow), 64'd0);
    end
    applyStimulus(1'b0, '0, 1'b0);
    #1 checkOutput("pin2_ovf_set", 64'(o_overflow), 64'd1);
    applyStimulus(1'b0, '0, 1'b0);
    #1 checkOutput("pin2_ovf_sticky", 64'(o_overflow), 64'd1);
    for (int j = 1; j <= 4; j++) begin
      applyStimulus(1'b0, '0, 1'b1);
      #1 checkOutput("pin2_drain", 64'(o_data), 64'(32'hA000_0000 + 32'(j)));
    end
    applyStimulus(1'b0, '0, 1'b0);
    #1 checkOutput("pin2_empty", 64'(o_valid), 64'd0);

    // Push into a full FIFO while popping.
    applyReset();
    for (int k = 1; k <= 4; k++) applyStimulus(1'b1, 32'hB000_0000 + 32'(k), 1'b0);
    applyStimulus(1'b1, 32'hB000_0005, 1'b1);
    #1 checkOutput("pin3_head", 64'(o_data), 64'h0000_0000_B000_0001);
    applyStimulus(1'b0, '0, 1'b0);
    #1;
    checkOutput("pin3_stall", 64'(o_stall), 64'd1);
    checkOutput("pin3_ovf", 64'(o_overflow), 64'd0);
    for (int j = 2; j <= 5; j++) begin
      applyStimulus(1'b0, '0, 1'b1);
      #1 checkOutput("pin3_order", 64'(o_data), 64'(32'hB000_0000 + 32'(j)));
    end

    // Toggled ready holds the head beat.
    for (int k = 1; k <= 3; k++) applyStimulus(1'b1, 32'hC000_0000 + 32'(k), 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    #1 checkOutput("pin4_d1", 64'(o_data), 64'h0000_0000_C000_0001);
    applyStimulus(1'b0, '0, 1'b0);
    #1 checkOutput("pin4_d2", 64'(o_data), 64'h0000_0000_C000_0002);
    applyStimulus(1'b0, '0, 1'b1);
    #1 checkOutput("pin4_d2_hold", 64'(o_data), 64'h0000_0000_C000_0002);
    applyStimulus(1'b0, '0, 1'b0);
    #1 checkOutput("pin4_d3", 64'(o_data), 64'h0000_0000_C000_0003);
    applyStimulus(1'b0, '0, 1'b1);
    #1 checkOutput("pin4_d3_hold", 64'(o_data), 64'h0000_0000_C000_0003);
    applyStimulus(1'b0, '0, 1'b0);
    #1 checkOutput("pin4_empty", 64'(o_valid), 64'd0);

    // Asynchronous reset mid-frame.
    applyReset();
    applyStimulus(1'b1, 32'hD000_0001, 1'b1);
    applyStimulus(1'b1, 32'hD000_0002, 1'b1);
    applyStimulus(1'b1, 32'hD000_0003, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    #1;
    checkOutput("pin5_pre_valid", 64'(o_valid), 64'd1);
    checkOutput("pin5_pre_x", 64'(o_x), 64'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("pin5_valid", 64'(o_valid), 64'd0);
    checkOutput("pin5_x", 64'(o_x), 64'd0);
    checkOutput("pin5_y", 64'(o_y), 64'd0);
    checkOutput("pin5_stall", 64'(o_stall), 64'd0);
    checkOutput("pin5_ovf", 64'(o_overflow), 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b1, 32'hD000_0004, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    #1;
    checkOutput("pin5_after_data", 64'(o_data), 64'h0000_0000_D000_0004);
    checkOutput("pin5_after_x", 64'(o_x), 64'd0);
    checkOutput("pin5_after_y", 64'(o_y), 64'd0);

`ifdef OFMAP_CHECKSUM_EN
    // Two frames of all-ones words: twelve -1 words per frame.
    applyReset();
    for (int f = 0; f < 2; f++) begin
      pulses = 0;
      seen_sum = '0;
      for (int k = 0; k < FRAME; k++) applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1);
      for (int s = 0; s < 4; s++) begin
        applyStimulus(1'b0, '0, 1'b1);
        #1;
        if (o_frame_sum_valid) begin
          pulses++;
          seen_sum = o_frame_sum;
        end
      end
      checkOutput("pin6_pulses", 64'(pulses), 64'd1);
      checkOutput("pin6_sum", 64'(seen_sum), 64'h0000_0000_FFFF_FFF4);
    end
`endif

    // Random traffic with varying backpressure, reset now and then.
    for (int n = 0; n < 3000; n++) begin
      if (n % 750 == 0) applyReset();
      if (n % 150 == 0) rp = $urandom_range(15, 95);
      applyStimulus(1'($urandom_range(0, 99) < 60), VW'($urandom),
                    1'($urandom_range(0, 99) < rp));
    end
    applyStimulus(1'b0, '0, 1'b1);
    repeat (8) @(negedge clk);

    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
